// File: rtl/seq_scan_arbiter_if.sv
// rtl/seq_scan_arbiter_if.sv - requester bus and serial/report outputs of the scan arbiter
interface seq_scan_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int CW    = 4
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ-1:0]    ack;
  logic                busy;
  logic                ser_valid;
  logic                ser_bit;
  logic                done;
  logic [IW-1:0]       done_id;
  logic [CW-1:0]       match_cnt;

  modport master (
    output req, data,
    input  ack, busy, ser_valid, ser_bit, done, done_id, match_cnt
  );

  modport slave (
    input  req, data,
    output ack, busy, ser_valid, ser_bit, done, done_id, match_cnt
  );
endinterface

// File: rtl/seq_scan_arbiter.sv
// rtl/seq_scan_arbiter.sv - round-robin arbiter feeding one shared overlapping "1001" detector
module seq_scan_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int CW    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_scan_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(DW + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]       state_q;
  logic [IW-1:0]    last_q, cur_q;
  logic [DW-1:0]    shift_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [2:0]       det_q, det_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q;
  logic             busy_q, ser_valid_q, ser_bit_q, done_q;
  logic [IW-1:0]    done_id_q;
  logic [CW-1:0]    match_cnt_q;

  logic             found;
  logic [IW-1:0]    win;
  int               idx;

  // Search starts one past the last winner and wraps, so every waiting requester is reached.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_q) + i) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Detector advances on the bit currently presented on ser_bit.
  always_comb begin
    det_d = S0;
    case (det_q)
      S0:      det_d = ser_bit_q ? S1 : S0;
      S1:      det_d = ser_bit_q ? S1 : S2;
      S2:      det_d = ser_bit_q ? S1 : S3;
      S3:      det_d = ser_bit_q ? S4 : S0;
      S4:      det_d = ser_bit_q ? S1 : S2;
      default: det_d = S0;
    endcase
    cnt_d = cnt_q;
    if (det_d == S4 && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= IW'(N_REQ - 1);
      cur_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      det_q       <= S0;
      cnt_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            ack_q[win]  <= 1'b1;
            last_q      <= win;
            cur_q       <= win;
            ser_bit_q   <= bus.data[int'(win)*DW + DW-1];
            shift_q     <= bus.data[int'(win)*DW +: DW] << 1;
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            bit_cnt_q   <= '0;
            det_q       <= S0;
            cnt_q       <= '0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          det_q     <= det_d;
          cnt_q     <= cnt_d;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DW - 1)) begin
            ser_valid_q <= 1'b0;
            ser_bit_q   <= 1'b0;
            done_q      <= 1'b1;
            done_id_q   <= cur_q;
            match_cnt_q <= cnt_d;
            state_q     <= REPORT;
          end else begin
            ser_bit_q <= shift_q[DW-1];
            shift_q   <= shift_q << 1;
          end
        end
        REPORT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_cnt_q;
endmodule
